// File: rtl/brailliance_pkg.sv
// Shared constants and types for the brailliance text path: NUL terminator,
// the boot message image and the text_buffer state encoding.
package brailliance_pkg;

    localparam logic [7:0] NUL_CHAR    = 8'h00;
    localparam int         PRELOAD_LEN = 15;

    // "Text to Braille", index 0 first
    localparam logic [0:PRELOAD_LEN-1][7:0] PRELOAD_BYTES = {
        8'h54, 8'h65, 8'h78, 8'h74, 8'h20, 8'h74, 8'h6F, 8'h20,
        8'h42, 8'h72, 8'h61, 8'h69, 8'h6C, 8'h6C, 8'h65
    };

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        STREAM = 2'd2
    } tb_state_e;

endpackage

// File: rtl/text_buffer_preload_rom.sv
// Combinational boot-image lookup: index -> preload byte, zero past the message.
module text_buffer_preload_rom
    import brailliance_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] idx,
    output logic [DATA_W-1:0] data
);

    // Constant-index compare keeps the lookup free of out-of-range selects
    always_comb begin
        data = '0;
        for (int i = 0; i < PRELOAD_LEN; i++) begin
            if (idx == ADDR_W'(i)) begin
                data = DATA_W'(PRELOAD_BYTES[i]);
            end else begin
                data = data;
            end
        end
    end

endmodule

// File: rtl/text_buffer.sv
// Character store with host write port, registered random read and a NUL-terminated
// character stream. Define TEXT_BUFFER_PRELOAD_EN to boot with the "Text to Braille" image.
module text_buffer
    import brailliance_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              strm_start,
    output logic              strm_valid,
    output logic [DATA_W-1:0] strm_data,
    output logic              strm_last,
    input  logic              strm_ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] NUL_W     = DATA_W'(NUL_CHAR);
`ifdef TEXT_BUFFER_PRELOAD_EN
    localparam bit PRELOAD_ON = 1'b1;
`else
    localparam bit PRELOAD_ON = 1'b0;
`endif

    logic [DATA_W-1:0] mem_r [DEPTH];
    tb_state_e         state_r;
    logic [ADDR_W-1:0] init_addr_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [DATA_W-1:0] rom_data_s;
    logic [DATA_W-1:0] init_data_s;
    logic [DATA_W-1:0] cur_char_s;
    logic [DATA_W-1:0] next_char_s;

    text_buffer_preload_rom #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rom (
        .idx  (init_addr_r),
        .data (rom_data_s)
    );

    // Init fill value plus the current/next characters used to decide strm_last
    always_comb begin
        init_data_s = PRELOAD_ON ? rom_data_s : '0;
        cur_char_s  = mem_r[ptr_r];
        next_char_s = mem_r[ptr_r + ADDR_W'(1)];
    end

    // Single write port: init sweep owns it in INIT, the host everywhere else
    always_ff @(posedge clk) begin
        if (!reset && state_r == INIT) begin
            mem_r[init_addr_r] <= init_data_s;
        end else if (!reset && wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Control FSM with registered read port and stream outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= INIT;
            init_addr_r <= '0;
            ptr_r       <= '0;
            busy        <= 1'b1;
            rd_data     <= '0;
            strm_valid  <= 1'b0;
            strm_data   <= '0;
            strm_last   <= 1'b0;
        end else begin
            rd_data <= mem_r[rd_addr];
            case (state_r)
                INIT: begin
                    init_addr_r <= init_addr_r + ADDR_W'(1);
                    if (init_addr_r == LAST_ADDR) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                IDLE: begin
                    if (strm_start) begin
                        state_r <= STREAM;
                        ptr_r   <= '0;
                    end
                end
                STREAM: begin
                    if (strm_valid) begin
                        if (strm_ready) begin
                            strm_valid <= 1'b0;
                            strm_last  <= 1'b0;
                            if (strm_last) begin
                                state_r <= IDLE;
                            end else begin
                                ptr_r <= ptr_r + ADDR_W'(1);
                            end
                        end
                    end else if (cur_char_s == NUL_W) begin
                        // Terminator reached before presenting anything (NUL at 0)
                        state_r <= IDLE;
                    end else begin
                        strm_valid <= 1'b1;
                        strm_data  <= cur_char_s;
                        strm_last  <= (ptr_r == LAST_ADDR) || (next_char_s == NUL_W);
                    end
                end
                default: state_r <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_text_buffer.sv
// Directed scoreboard bench for text_buffer; expectations come from a bench-side memory model.
module tb_text_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              busy;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              strm_start = 1'b0;
    logic              strm_valid;
    logic [DATA_W-1:0] strm_data;
    logic              strm_last;
    logic              strm_ready = 1'b0;

    logic [7:0] msg   [15];
    logic [7:0] image [DEPTH];
    logic [7:0] model [DEPTH];
    logic [7:0] rd_q   [$];
    logic [8:0] strm_q [$];
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    text_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .busy       (busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .strm_start (strm_start),
        .strm_valid (strm_valid),
        .strm_data  (strm_data),
        .strm_last  (strm_last),
        .strm_ready (strm_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_init(input bit poke);
        int cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            cnt++;
            wr_en   = poke && (cnt == 100);
            wr_addr = 8'd5;
            wr_data = 8'h55;
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("init_busy_cycles", cnt, 256);
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic host_read(input string tag, input logic [7:0] a);
        rd_addr = a;
        rd_q.push_back(model[a]);
        @(negedge clk);
        check(tag, rd_data, rd_q.pop_front());
    endtask

    task automatic run_stream(input bit rnd, input int abort_after);
        logic [8:0] e;
        logic [7:0] held = 8'h00;
        bit stalled = 1'b0;
        bit done = 1'b0;
        int hs = 0;
        int cyc = 0;
        strm_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            if (model[i] == 8'h00) break;
            strm_q.push_back({(i == DEPTH - 1) ? 1'b1 : (model[i + 1] == 8'h00), model[i]});
        end
        strm_start = 1'b1;
        @(negedge clk);
        strm_start = 1'b0;
        while (!done && cyc < 600) begin
            if (stalled) begin
                check("stall_valid", strm_valid, 1);
                check("stall_data", strm_data, held);
            end
            strm_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = strm_valid && !strm_ready;
            held = strm_data;
            if (strm_valid && strm_ready) begin
                if (strm_q.size() == 0) begin
                    check("strm_extra_byte", 1, 0);
                    done = 1'b1;
                end else begin
                    e = strm_q.pop_front();
                    check("strm_data", strm_data, e[7:0]);
                    check("strm_last", strm_last, e[8]);
                    hs++;
                    if (e[8]) done = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
            if (abort_after > 0 && hs == abort_after) break;
        end
        strm_ready = 1'b0;
        if (abort_after > 0) begin
            check("abort_handshakes", hs, abort_after);
        end else begin
            check("strm_completed", done, 1);
            check("strm_bytes_left", strm_q.size(), 0);
            for (int k = 0; k < 4; k++) begin
                check("after_last_valid", strm_valid, 0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int pulses;
        msg = '{8'h54, 8'h65, 8'h78, 8'h74, 8'h20, 8'h74, 8'h6F, 8'h20,
                8'h42, 8'h72, 8'h61, 8'h69, 8'h6C, 8'h6C, 8'h65};
        for (int i = 0; i < DEPTH; i++) image[i] = 8'h00;
`ifdef TEXT_BUFFER_PRELOAD_EN
        for (int i = 0; i < 15; i++) image[i] = msg[i];
`endif
        for (int i = 0; i < DEPTH; i++) model[i] = image[i];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_valid", strm_valid, 0);
        check("rst_last", strm_last, 0);
        check("rst_strm_data", strm_data, 0);
        check("rst_rd_data", rd_data, 0);

        // Init sweep, with a host write attempted mid-init
        reset = 1'b0;
        wait_init(1'b1);
        host_read("rd_addr8", 8'd8);
        host_read("rd_addr15", 8'd15);
        host_read("init_write_ignored", 8'd5);

        // Load the message through the host port (no-op change when preloaded)
        for (int i = 0; i < 15; i++) host_write(8'(i), msg[i]);
        host_read("host_write_readback", 8'd14);

        // Read-before-write on address 3
        wr_en = 1'b1; wr_addr = 8'd3; wr_data = 8'h41; rd_addr = 8'd3;
        rd_q.push_back(model[3]);
        @(negedge clk);
        wr_en = 1'b0;
        check("rbw_old", rd_data, rd_q.pop_front());
        model[3] = 8'h41;
        host_read("rbw_new", 8'd3);
        host_write(8'd3, 8'h74);

        // Streams: always-ready, then random backpressure
        run_stream(1'b0, 0);
        run_stream(1'b1, 0);

        // NUL at address 0 produces no character
        host_write(8'd0, 8'h00);
        strm_start = 1'b1;
        @(negedge clk);
        strm_start = 1'b0;
        strm_ready = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (strm_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        strm_ready = 1'b0;
        check("nul0_no_valid", pulses, 0);
        host_write(8'd0, 8'h54);

        // Reset after 5 handshakes
        run_stream(1'b0, 5);
        reset = 1'b1;
        @(negedge clk);
        check("abort_valid", strm_valid, 0);
        check("abort_busy", busy, 1);
        check("abort_strm_data", strm_data, 0);
        reset = 1'b0;
        wait_init(1'b0);
        for (int i = 0; i < DEPTH; i++) model[i] = image[i];
        host_read("restore_0", 8'd0);
        host_read("restore_3", 8'd3);
        host_read("restore_8", 8'd8);
        host_read("restore_14", 8'd14);
        host_read("restore_15", 8'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/text_buffer.md
TEXT_BUFFER -- requirements
Module: text_buffer

Interface
REQ-001 Parameter DATA_W, default 8: character width in bits.
REQ-002 Parameter DEPTH, default 256: number of words; power of two, at least 16.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH): address width.
REQ-004 clk  in  1: single clock; all logic on the rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 busy  out  1: high while initialisation runs.
REQ-007 wr_en, wr_addr, wr_data  in  1/ADDR_W/DATA_W: host write port.
REQ-008 rd_addr  in  ADDR_W: random-access read address, from size_calculator.
REQ-009 rd_data  out  DATA_W: registered random-access read data.
REQ-010 strm_start  in  1: begin streaming from address 0.
REQ-011 strm_valid, strm_data, strm_last  out  1/DATA_W/1: character stream to braille_converter.
REQ-012 strm_ready  in  1: consumer accepts the character when both strm_valid and strm_ready are high.

Function
REQ-013 The block shall implement an FSM with states INIT, IDLE and STREAM.
REQ-014 INIT shall write one word per cycle at addresses 0..DEPTH-1, using the preload value or 0, then enter IDLE; busy=1 throughout, so INIT lasts exactly DEPTH cycles.
REQ-015 rd_data shall equal mem[rd_addr] one cycle after rd_addr is sampled, in every state.
REQ-016 A write with wr_en=1 in IDLE or STREAM shall update mem[wr_addr] at the clock edge.
REQ-017 A write in INIT shall be ignored.
REQ-018 A read of the address being written in the same cycle shall return the old data (read-before-write).
REQ-019 strm_start in IDLE shall enter STREAM with the stream pointer at 0.
REQ-020 strm_start in INIT or STREAM shall be ignored.
REQ-021 In STREAM, strm_valid shall rise at most 2 cycles after strm_start; strm_data shall hold mem[ptr].
REQ-022 strm_data and strm_valid shall stay stable until the handshake completes.
REQ-023 On each handshake the pointer shall increment by 1.
REQ-024 strm_last shall be 1 with the final character, which is the one at DEPTH-1 or the one followed by a NUL (8'h00) word.
REQ-025 A NUL word itself shall never be streamed.
REQ-026 A NUL at address 0 shall cause the FSM to return to IDLE with no strm_valid pulse.
REQ-027 After the handshake where strm_last=1, the FSM shall return to IDLE next cycle; the pointer shall not wrap.
REQ-028 A write to an address ahead of ptr during STREAM shall be visible when ptr reaches it.
REQ-029 A write to ptr's current address while strm_valid=1 shall not alter the presented strm_data.

Reset
REQ-030 reset=1 shall force INIT and ptr=0 at the next edge, aborting any stream.
REQ-031 While reset=1: busy=1, strm_valid=0, strm_last=0, strm_data=0, rd_data=0.
REQ-032 Initialisation shall start on the first cycle after reset deasserts.

Configuration
REQ-033 With TEXT_BUFFER_PRELOAD_EN defined, INIT shall write the 15-byte message "Text to Braille" (54 65 78 74 20 74 6F 20 42 72 61 69 6C 6C 65) to addresses 0..14 and 0 elsewhere.
REQ-034 Without the macro, INIT shall write 0 to every address.

Structure
REQ-035 Package brailliance_pkg shall hold NUL_CHAR, PRELOAD_LEN, the preload byte constant array and the state enum type.
REQ-036 One sub-module, text_buffer_preload_rom, shall be instantiated: combinational, index to preload byte, 0 beyond PRELOAD_LEN.

Verification
REQ-037 Release reset, PRELOAD_EN defined -> busy=1 for 256 cycles; then rd_addr=8 returns 8'h42 and rd_addr=15 returns 8'h00.
REQ-038 strm_start with strm_ready=1 constantly -> 15 handshakes, bytes 54..65 in order, strm_last only on 8'h65, IDLE next cycle.
REQ-039 strm_ready toggled randomly during the stream -> strm_data/strm_valid held while stalled, no byte lost or duplicated.
REQ-040 Write 8'h00 to address 0 in IDLE, then strm_start -> no strm_valid pulse, return to IDLE.
REQ-041 Same-cycle wr_addr=rd_addr=3 with wr_data=8'h41 -> rd_data=8'h74 next cycle, 8'h41 on the following read.
REQ-042 reset asserted mid-stream after 5 handshakes -> strm_valid=0 next cycle, INIT restarts, memory restored to the preload image.
